// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-ported word memory behind a valid/ready request channel and a
//   valid/ready response channel. Each accepted request passes through a
//   programmable number of wait states, performs one memory access, and then
//   holds its response until the initiator takes it. Only one request is in
//   flight at a time; requests presented while busy are ignored, not queued.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, 16..65536)
//   WAIT_CYCLES : wait states inserted per access (0..15)
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (memory contents are kept)
//   req_valid  : request present
//   req_ready  : responder idle and able to accept (registered)
//   req_we     : 1 = write, 0 = read
//   req_addr   : byte address; wraps modulo DEPTH_WORDS*4
//   req_wdata  : write data
//   req_be     : byte-lane write enables, bit i covers bits [8i+7:8i]
//   resp_valid : response present (registered)
//   resp_ready : initiator accepts the response
//   resp_rdata : read data, 0 for write responses (registered)
//   resp_err   : misaligned-access flag (registered)
//
// Build option
//   MEM_RESPONDER_ALIGN_CHECK_EN : when defined, requests with addr[1:0] != 0
//   skip the memory access and respond with resp_err=1, resp_rdata=0 after
//   the normal latency. When undefined, resp_err is always 0 and addr[1:0]
//   is ignored.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW  = 4;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = DataW / 8;

  // Elaboration-time parameter sanity checks.
  if ((DEPTH_WORDS < 16) || (DEPTH_WORDS > 65536) ||
      ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
    $error("mem_responder: DEPTH_WORDS must be a power of two in 16..65536");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic                 we_q;
  logic [IdxW-1:0]      idx_q;
  logic [1:0]           off_q;
  logic [DataW-1:0]     wdata_q;
  logic [BeW-1:0]       be_q;

  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DataW-1:0]     resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;

  logic [DataW-1:0]     mem_q [DEPTH_WORDS];

  logic                 accept_c;
  logic                 misaligned_c;
  logic                 mem_we_c;
  logic                 unused_c;

  // A request is taken whenever the registered ready meets a valid.
  assign accept_c = req_valid & req_ready_q;

  // Alignment check on the captured byte offset.
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned_c = (off_q != 2'b00);
`else
  assign misaligned_c = 1'b0;
`endif

  // Memory is written only while leaving ACCESS, and never on a reset edge.
  assign mem_we_c = (state_q == S_ACCESS) & we_q & ~misaligned_c & ~reset;

  // Upper address bits wrap away by design; the offset is only consulted
  // when the alignment check is built in.
  assign unused_c = ^{req_addr[31:IdxW+2], off_q};

  // ---------------------------------------------------------------------------
  // FSM process 1: state and wait-counter register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state and wait-counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CntW'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        // The counter holds the wait cycles still to spend, this one included.
        if (cnt_q <= CntW'(1)) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (state_q == S_ACCESS) begin
      resp_err_d = misaligned_c;
      if (we_q || misaligned_c) begin
        resp_rdata_d = '0;
      end else begin
        resp_rdata_d = mem_q[idx_q];
      end
    end
  end

  // Registered outputs; ready comes up out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request capture; the req_* inputs are not looked at again until IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept_c) begin
      we_q    <= req_we;
      idx_q   <= req_addr[2 +: IdxW];
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Storage array with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .DEPTH_WORDS (16),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one request, then scrambles req_* after acceptance and counts
  // edges until resp_valid is seen (bounded). Returns at posedge+1.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Samples the response and completes the handshake on the next edge.
  task automatic complete(output logic [31:0] rdata, output logic err);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    complete(rd, er);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h expected 0", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", er); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_valid_drop: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_back: got %b expected 1", req_ready); end
    // Back-to-back read of the same word must see the new data.
    issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    complete(rd, er);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_enable;
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, lat); complete(rd, er);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat); complete(rd, er);
    issue(1'b0, 32'h20, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0101: got %h expected 11bb33dd", rd); end
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL be_0000_resp: got latency %0d expected 3", lat); end
    complete(rd, er);
    issue(1'b0, 32'h20, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0000_nochange: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'h40, 32'h5, 4'hF, lat); complete(rd, er);
    issue(1'b0, 32'h0, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL wrap_0x0: got %h expected 5", rd); end
    issue(1'b0, 32'hFFFF_FF80, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL wrap_high: got %h expected 5", rd); end
  endtask

  task automatic test_hold;
    int lat; logic [31:0] rd; logic er;
    issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i % 2 == 0); req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      @(posedge clk);
      #1;
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, resp_valid); end
      n_checks++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_rdata[%0d]: got %h expected deadbeef", i, resp_rdata); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, req_ready); end
    end
    req_valid = 1'b0;
    complete(rd, er);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_final: got %h expected deadbeef", rd); end
    // Ignored pulses must not have left a queued transaction behind.
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_queue: got %b expected 0", resp_valid); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_mem_intact: got %h expected deadbeef", rd); end
  endtask

  task automatic test_reset_in_wait;
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'h8, 32'h0BADF00D, 4'hF, lat); complete(rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h1; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy: got %b expected 0", req_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_idle: got %b expected 1", req_ready); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_no_resp: got %b expected 0", resp_valid); end
    issue(1'b0, 32'h8, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rstwait_old_data: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_reset_in_access;
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'hC, 32'hCAFEF00D, 4'hF, lat); complete(rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'h1; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstacc_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rstacc_rdata: got %h expected 0", resp_rdata); end
    issue(1'b0, 32'hC, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rstacc_old_data: got %h expected cafef00d", rd); end
  endtask

  task automatic test_align;
    int lat; logic [31:0] rd; logic er;
    logic        exp_err;
    logic [31:0] exp_word;
    logic [31:0] exp_mis_rd;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_word = 32'hDEADBEEF; exp_mis_rd = 32'h0;
`else
    exp_err = 1'b0; exp_word = 32'h12345678; exp_mis_rd = 32'h12345678;
`endif
    issue(1'b1, 32'h13, 32'h12345678, 4'hF, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL align_latency: got %0d expected 3", lat); end
    complete(rd, er);
    n_checks++; if (er !== exp_err) begin n_fail++; $display("FAIL align_wr_err: got %b expected %b", er, exp_err); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL align_wr_rdata: got %h expected 0", rd); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== exp_word) begin n_fail++; $display("FAIL align_word: got %h expected %h", rd, exp_word); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL align_aligned_err: got %b expected 0", er); end
    issue(1'b0, 32'h11, 32'h0, 4'h0, lat); complete(rd, er);
    n_checks++; if (rd !== exp_mis_rd) begin n_fail++; $display("FAIL align_rd_rdata: got %h expected %h", rd, exp_mis_rd); end
    n_checks++; if (er !== exp_err) begin n_fail++; $display("FAIL align_rd_err: got %b expected %b", er, exp_err); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_wrap();
    test_hold();
    test_reset_in_wait();
    test_reset_in_access();
    test_align();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored; it must be a power of two, from 16 to 65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states inserted per access; range 0..15.
REQ-003 SHALL have port clk, input, width 1, the single clock; every flop is rising-edge.
REQ-004 SHALL have port reset, input, width 1, a synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, width 1; the initiator asserts it to present a request.
REQ-006 SHALL have port req_ready, output, width 1; the responder asserts it when it can accept a request.
REQ-007 SHALL have port req_we, input, width 1; 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, width 32, the byte address.
REQ-009 SHALL have port req_wdata, input, width 32, the write data.
REQ-010 SHALL have port req_be, input, width 4, the byte-lane write enables; bit i enables bits [8i+7:8i].
REQ-011 SHALL have port resp_valid, output, width 1, marking the response as valid.
REQ-012 SHALL have port resp_ready, input, width 1; the initiator asserts it to accept the response.
REQ-013 SHALL have port resp_rdata, output, width 32, the read data.
REQ-014 SHALL have port resp_err, output, width 1, the misaligned-access error flag (see Configuration).

Function
REQ-015 SHALL implement the states IDLE, WAIT, ACCESS and RESP, with registered outputs only.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on any edge where req_valid and req_ready are both 1.
REQ-017 SHALL, on acceptance, capture req_we, req_addr, req_wdata and req_be into internal registers; later changes on the req_* inputs SHALL have no effect.
REQ-018 SHALL transition from IDLE to WAIT on acceptance, loading the wait counter with WAIT_CYCLES; if WAIT_CYCLES=0 it SHALL go directly to ACCESS.
REQ-019 SHALL remain in WAIT for exactly WAIT_CYCLES cycles, then go to ACCESS.
REQ-020 SHALL spend exactly one cycle in ACCESS, then go to RESP; resp_valid SHALL first be high in the cycle after edge E0+WAIT_CYCLES+1, where E0 is the acceptance edge.
REQ-021 SHALL compute the word index as addr[2 +: log2(DEPTH_WORDS)]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-022 SHALL, on a write in ACCESS, update only the bytes whose req_be bit is 1; be=4'b0000 SHALL change nothing but still produce a response.
REQ-023 SHALL, on a read in ACCESS, register the addressed word into resp_rdata; a write response SHALL drive resp_rdata=0.
REQ-024 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then clear resp_valid and return to IDLE on that edge.
REQ-025 SHALL NOT accept a new request in the cycle where the response handshake completes; the earliest next acceptance is on the following edge.
REQ-026 SHALL ignore req_valid in WAIT, ACCESS and RESP; nothing is queued.
REQ-027 SHALL make a write immediately followed by a read of the same word return the new data.

Reset
REQ-028 SHALL, while reset=1 at an edge, enter IDLE with req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 and the wait counter at 0.
REQ-029 SHALL, on reset during WAIT, discard the pending write; a reset coinciding with the ACCESS edge SHALL suppress the write.
REQ-030 SHALL NOT clear memory contents on reset.

Configuration
REQ-031 SHALL, when macro MEM_RESPONDER_ALIGN_CHECK_EN is defined, flag any captured request with addr[1:0]!=0 as follows:
- no memory read or write takes place
- the response carries resp_err=1 and resp_rdata=0
- the latency is unchanged
REQ-032 SHALL, when MEM_RESPONDER_ALIGN_CHECK_EN is undefined, tie resp_err to 0 and ignore addr[1:0].

Verification
REQ-033 SHALL cover this case: reset, then WAIT_CYCLES=2, a write to 0x10 of 0xDEADBEEF with be=F, then a read of 0x10 -> resp_rdata=0xDEADBEEF; resp_valid first seen 3 cycles after the acceptance edge.
REQ-034 SHALL cover this case: word 0x20 holds 0x11223344, then a write of 0xAABBCCDD with be=4'b0101, then a read -> 0x11BB33DD.
REQ-035 SHALL cover this case: DEPTH_WORDS=16, a write of 0x5 to 0x40, then a read of 0x0 -> 0x5 (wrap).
REQ-036 SHALL cover this case: resp_ready held low for 5 cycles in RESP -> resp_valid and resp_rdata stay constant and req_ready stays 0 throughout; req_valid pulses are ignored.
REQ-037 SHALL cover this case: reset asserted in WAIT during a write of 0x1 to 0x8 -> IDLE next cycle, and a later read of 0x8 returns the old value.
REQ-038 SHALL cover this case: with MEM_RESPONDER_ALIGN_CHECK_EN defined, a write to 0x13 -> resp_err=1 and memory is unchanged; with the macro undefined -> resp_err=0 and word 0x10 is written.
